// File: rtl/harvard_sched_pkg.sv
// Shared types for the Harvard memory scheduler.
// State encoding and I-port constant lane select.
package harvard_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } sched_state_t;

  localparam logic [1:0] I_BYTESEL_ALL = 2'b11;

endpackage

// File: rtl/harvard_starve_counter.sv
// Saturating count of D grants taken while I waits.
// Raises prio_i once the limit is reached.
module harvard_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_prio_i
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat    = (r_cnt >= CNT_W'(STARVE_LIMIT));
  assign o_prio_i = w_sat;

  // Clear on an I grant, else count up to the limit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/harvard_mem_scheduler.sv
// Single memory port shared by I-cache and D-cache
// miss paths; D priority, I starvation guard, burst lock.
module harvard_mem_scheduler
  import harvard_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:1] icache_m_addr,
  output logic [15:0] icache_m_data_in,
  input  logic        icache_m_access,
  output logic        icache_m_ack,
  input  logic [19:1] dcache_m_addr,
  output logic [15:0] dcache_m_data_in,
  input  logic [15:0] dcache_m_data_out,
  input  logic        dcache_m_access,
  output logic        dcache_m_ack,
  input  logic        dcache_m_wr_en,
  input  logic [1:0]  dcache_m_bytesel,
  output logic [19:1] mem_m_addr,
  input  logic [15:0] mem_m_data_in,
  output logic [15:0] mem_m_data_out,
  output logic        mem_m_access,
  input  logic        mem_m_ack,
  output logic        mem_m_wr_en,
  output logic [1:0]  mem_m_bytesel,
  output logic        grant_i,
  output logic        grant_d
);

  sched_state_t r_state;
  logic         w_prio_i;
  logic         w_idle;
  logic         w_pick_d;
  logic         w_pick_i;
  logic         w_inc;
  logic         w_clr;

  assign w_idle   = (r_state == IDLE);
  assign w_pick_d = dcache_m_access &&
                    (!icache_m_access || !w_prio_i);
  assign w_pick_i = !w_pick_d && icache_m_access;
  assign w_inc    = w_idle && w_pick_d && icache_m_access;
  assign w_clr    = w_idle && w_pick_i;

  harvard_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_inc    (w_inc),
    .i_clr    (w_clr),
    .o_prio_i (w_prio_i)
  );

  // Arbitrate in IDLE; hold the grant until access drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_d)      r_state <= SERVE_D;
          else if (w_pick_i) r_state <= SERVE_I;
        end
        SERVE_I: if (!icache_m_access) r_state <= IDLE;
        SERVE_D: if (!dcache_m_access) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_i = (r_state == SERVE_I);
  assign grant_d = (r_state == SERVE_D);

  // Route the granted port onto memory and the ack back.
  always_comb begin
    mem_m_access     = 1'b0;
    mem_m_addr       = '0;
    mem_m_data_out   = '0;
    mem_m_wr_en      = 1'b0;
    mem_m_bytesel    = 2'b00;
    icache_m_ack     = 1'b0;
    dcache_m_ack     = 1'b0;
    icache_m_data_in = mem_m_data_in;
    dcache_m_data_in = mem_m_data_in;
    unique case (1'b1)
      grant_i: begin
        mem_m_access  = icache_m_access;
        mem_m_addr    = icache_m_addr;
        mem_m_bytesel = I_BYTESEL_ALL;
        icache_m_ack  = mem_m_ack;
      end
      grant_d: begin
        mem_m_access   = dcache_m_access;
        mem_m_addr     = dcache_m_addr;
        mem_m_data_out = dcache_m_data_out;
        mem_m_wr_en    = dcache_m_wr_en;
        mem_m_bytesel  = dcache_m_bytesel;
        dcache_m_ack   = mem_m_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_harvard_mem_scheduler.sv
// Directed-vector bench for harvard_mem_scheduler.
// Bench drives the memory side directly.
module tb_harvard_mem_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:1] icache_m_addr;
  logic [15:0] icache_m_data_in;
  logic        icache_m_access;
  logic        icache_m_ack;
  logic [19:1] dcache_m_addr;
  logic [15:0] dcache_m_data_in;
  logic [15:0] dcache_m_data_out;
  logic        dcache_m_access;
  logic        dcache_m_ack;
  logic        dcache_m_wr_en;
  logic [1:0]  dcache_m_bytesel;
  logic [19:1] mem_m_addr;
  logic [15:0] mem_m_data_in;
  logic [15:0] mem_m_data_out;
  logic        mem_m_access;
  logic        mem_m_ack;
  logic        mem_m_wr_en;
  logic [1:0]  mem_m_bytesel;
  logic        grant_i;
  logic        grant_d;

  int n_vec = 0;
  int n_err = 0;

  harvard_mem_scheduler #(
    .STARVE_LIMIT (4),
    .CNT_W        (4)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .icache_m_addr     (icache_m_addr),
    .icache_m_data_in  (icache_m_data_in),
    .icache_m_access   (icache_m_access),
    .icache_m_ack      (icache_m_ack),
    .dcache_m_addr     (dcache_m_addr),
    .dcache_m_data_in  (dcache_m_data_in),
    .dcache_m_data_out (dcache_m_data_out),
    .dcache_m_access   (dcache_m_access),
    .dcache_m_ack      (dcache_m_ack),
    .dcache_m_wr_en    (dcache_m_wr_en),
    .dcache_m_bytesel  (dcache_m_bytesel),
    .mem_m_addr        (mem_m_addr),
    .mem_m_data_in     (mem_m_data_in),
    .mem_m_data_out    (mem_m_data_out),
    .mem_m_access      (mem_m_access),
    .mem_m_ack         (mem_m_ack),
    .mem_m_wr_en       (mem_m_wr_en),
    .mem_m_bytesel     (mem_m_bytesel),
    .grant_i           (grant_i),
    .grant_d           (grant_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_starve.r_cnt);
  endfunction

  initial begin
    reset_n           = 1'b0;
    icache_m_addr     = '0;
    icache_m_access   = 1'b0;
    dcache_m_addr     = '0;
    dcache_m_data_out = '0;
    dcache_m_access   = 1'b0;
    dcache_m_wr_en    = 1'b0;
    dcache_m_bytesel  = 2'b00;
    mem_m_data_in     = '0;
    mem_m_ack         = 1'b0;

    // reset state
    step(); step();
    chk("rst_acc", 32'(mem_m_access), 0);
    chk("rst_gi", 32'(grant_i), 0);
    chk("rst_gd", 32'(grant_d), 0);
    chk("rst_addr", 32'(mem_m_addr), 0);
    chk("rst_bsel", 32'(mem_m_bytesel), 0);
    chk("rst_cnt", cnt(), 0);
    reset_n = 1'b1;
    step();

    // 1: single I read
    icache_m_addr   = 19'h00100;
    icache_m_access = 1'b1;
    #1;
    chk("t1_idle_acc", 32'(mem_m_access), 0);
    step();
    chk("t1_gi", 32'(grant_i), 1);
    chk("t1_acc", 32'(mem_m_access), 1);
    chk("t1_addr", 32'(mem_m_addr), 32'h100);
    chk("t1_bsel", 32'(mem_m_bytesel), 3);
    chk("t1_iack0", 32'(icache_m_ack), 0);
    step();
    step();
    mem_m_ack     = 1'b1;
    mem_m_data_in = 16'h1234;
    #1;
    chk("t1_iack", 32'(icache_m_ack), 1);
    chk("t1_idata", 32'(icache_m_data_in), 32'h1234);
    chk("t1_dack", 32'(dcache_m_ack), 0);
    step();
    mem_m_ack       = 1'b0;
    icache_m_access = 1'b0;
    #1;
    chk("t1_rel_acc", 32'(mem_m_access), 0);
    step();
    chk("t1_idle_gi", 32'(grant_i), 0);

    // 2: simultaneous requests, D first
    icache_m_addr   = 19'h00111;
    dcache_m_addr   = 19'h00222;
    icache_m_access = 1'b1;
    dcache_m_access = 1'b1;
    step();
    chk("t2_gd", 32'(grant_d), 1);
    chk("t2_gi", 32'(grant_i), 0);
    chk("t2_addr", 32'(mem_m_addr), 32'h222);
    chk("t2_cnt", cnt(), 1);
    mem_m_ack = 1'b1;
    #1;
    chk("t2_dack", 32'(dcache_m_ack), 1);
    chk("t2_iack", 32'(icache_m_ack), 0);
    step();
    mem_m_ack       = 1'b0;
    dcache_m_access = 1'b0;
    step();
    chk("t2_turn_acc", 32'(mem_m_access), 0);
    chk("t2_turn_gi", 32'(grant_i), 0);
    chk("t2_turn_gd", 32'(grant_d), 0);
    step();
    chk("t2_gi2", 32'(grant_i), 1);
    chk("t2_cnt0", cnt(), 0);
    icache_m_access = 1'b0;
    step();

    // 3: starvation guard, limit 4
    icache_m_access = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dcache_m_access = 1'b1;
      step();
      if (k < 4) begin
        chk("t3_gd", 32'(grant_d), 1);
        chk("t3_cnt", cnt(), 32'(k + 1));
        mem_m_ack = 1'b1;
        step();
        mem_m_ack       = 1'b0;
        dcache_m_access = 1'b0;
        step();
      end else begin
        chk("t3_gi", 32'(grant_i), 1);
        chk("t3_gd5", 32'(grant_d), 0);
        chk("t3_cnt0", cnt(), 0);
      end
    end
    dcache_m_access = 1'b0;
    icache_m_access = 1'b0;
    step();
    chk("t3_idle", 32'(grant_i), 0);

    // 4: I burst lock with D arriving mid-burst
    icache_m_addr   = 19'h00200;
    icache_m_access = 1'b1;
    step();
    for (int w = 0; w < 8; w++) begin
      icache_m_addr = 19'(19'h00200 + w);
      mem_m_ack     = 1'b1;
      mem_m_data_in = 16'(16'h5a00 + w);
      #1;
      chk("t4_addr", 32'(mem_m_addr), 32'(32'h200 + w));
      chk("t4_iack", 32'(icache_m_ack), 1);
      chk("t4_dack", 32'(dcache_m_ack), 0);
      step();
      if (w == 1) begin
        dcache_m_addr   = 19'h0ABCD;
        dcache_m_access = 1'b1;
      end
    end
    mem_m_ack       = 1'b0;
    icache_m_access = 1'b0;
    #1;
    chk("t4_rel_acc", 32'(mem_m_access), 0);
    chk("t4_rel_gd", 32'(grant_d), 0);
    step();
    chk("t4_turn_gd", 32'(grant_d), 0);
    chk("t4_turn_acc", 32'(mem_m_access), 0);
    step();
    chk("t4_gd", 32'(grant_d), 1);

    // 5: D write passthrough, then I grant
    dcache_m_wr_en    = 1'b1;
    dcache_m_bytesel  = 2'b10;
    dcache_m_data_out = 16'hBEEF;
    #1;
    chk("t5_addr", 32'(mem_m_addr), 32'h0ABCD);
    chk("t5_wr", 32'(mem_m_wr_en), 1);
    chk("t5_bsel", 32'(mem_m_bytesel), 2);
    chk("t5_dout", 32'(mem_m_data_out), 32'hBEEF);
    mem_m_ack = 1'b1;
    step();
    mem_m_ack       = 1'b0;
    dcache_m_access = 1'b0;
    icache_m_addr   = 19'h00300;
    icache_m_access = 1'b1;
    step();
    step();
    chk("t5_gi", 32'(grant_i), 1);
    chk("t5_iwr", 32'(mem_m_wr_en), 0);
    chk("t5_ibsel", 32'(mem_m_bytesel), 3);
    chk("t5_idout", 32'(mem_m_data_out), 0);
    icache_m_access = 1'b0;
    dcache_m_wr_en  = 1'b0;
    step();

    // 6: reset mid D burst
    icache_m_access = 1'b1;
    dcache_m_access = 1'b1;
    step();
    chk("t6_gd", 32'(grant_d), 1);
    chk("t6_cnt1", cnt(), 1);
    mem_m_ack = 1'b1;
    #1;
    chk("t6_dack", 32'(dcache_m_ack), 1);
    reset_n = 1'b0;
    step();
    chk("t6_gd0", 32'(grant_d), 0);
    chk("t6_acc0", 32'(mem_m_access), 0);
    chk("t6_cnt0", cnt(), 0);
    chk("t6_dack0", 32'(dcache_m_ack), 0);
    step();
    chk("t6_dack1", 32'(dcache_m_ack), 0);
    chk("t6_iack1", 32'(icache_m_ack), 0);
    mem_m_ack = 1'b0;
    reset_n   = 1'b1;
    step();
    chk("t6_regrant", 32'(grant_d), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
